// File: rtl/ising_config_pkg.sv
// Shared capture definitions: state and mode encodings, GPIO register map, default widths.
package ising_config;

   localparam int DATA_W_DEF = 128;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_t;

   typedef enum logic [1:0] {
      MODE_MAC  = 2'b00,
      MODE_NL   = 2'b01,
      MODE_RR   = 2'b10,
      MODE_RSVD = 2'b11
   } cap_mode_t;

   // GPIO register map seen by the CPU for arming and status readback
   localparam logic [7:0] GPIO_ADDR_CFG_CTRL  = 8'h00;
   localparam logic [7:0] GPIO_ADDR_CFG_COUNT = 8'h04;
   localparam logic [7:0] GPIO_ADDR_STATUS    = 8'h08;
   localparam logic [7:0] GPIO_ADDR_CAPTURED  = 8'h0C;
   localparam logic [7:0] GPIO_ADDR_OUT_SLICE = 8'h10;

   // Which sources may be granted in a given mode: bit0 = MAC, bit1 = NL
   function automatic logic [1:0] modeMask(input cap_mode_t mode);
      case (mode)
         MODE_MAC: modeMask = 2'b01;
         MODE_NL:  modeMask = 2'b10;
         MODE_RR:  modeMask = 2'b11;
         default:  modeMask = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/readback_rr_grant.sv
// Two-requester work-conserving round-robin grant; a masked-off source is never granted.
module readback_rr_grant (
   input  logic [1:0] i_req,
   input  logic [1:0] i_mask,
   input  logic       i_ptr,
   output logic       o_gnt
);

   logic [1:0] w_cand;

   // Preferred source wins if it has data, otherwise the other eligible one; with no data,
   // park on an eligible source so a single-source mode never points at the wrong side.
   always_comb begin
      w_cand = i_req & i_mask;
      if (w_cand[i_ptr])
         o_gnt = i_ptr;
      else if (w_cand[~i_ptr])
         o_gnt = ~i_ptr;
      else if (i_mask[i_ptr])
         o_gnt = i_ptr;
      else
         o_gnt = ~i_ptr;
   end

endmodule

// File: rtl/readback_capture_arbiter.sv
// Arms, triggers and arbitrates MAC/NL ADC beats into the CPU readback stream.
// Optional capture watchdog enabled by defining CAPTURE_TIMEOUT_EN.
module readback_capture_arbiter
   import ising_config::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_arm,
   input  logic              cfg_abort,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic              trig,
   input  logic [DATA_W-1:0] mac_data,
   input  logic              mac_valid,
   output logic              mac_ready,
   input  logic [DATA_W-1:0] nl_data,
   input  logic              nl_valid,
   output logic              nl_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_src,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  captured,
   output logic              timeout
);

   cap_state_t        r_state;
   cap_state_t        w_nextState;
   cap_mode_t         r_mode;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_captured;
   logic              r_grant;
   logic [DATA_W-1:0] r_outData;
   logic              r_outSrc;
   logic              r_outValid;

   logic       w_gnt;
   logic [1:0] w_mask;
   logic       w_accept;
   logic       w_srcValid;
   logic       w_fire;
   logic       w_lastBeat;
   logic       w_armOk;
   logic       w_timeoutHit;

   assign w_mask     = modeMask(r_mode);
   assign w_accept   = !r_outValid || out_ready;
   assign w_srcValid = w_gnt ? nl_valid : mac_valid;
   assign w_fire     = (r_state == ST_CAPTURE) && w_accept && w_srcValid && !cfg_abort;
   assign w_lastBeat = w_fire && ((r_captured + 1'b1) == r_count);

   // Re-arming from DONE waits until the last beat has been drained by the reader
   assign w_armOk = cfg_arm && (cap_mode_t'(cfg_mode) != MODE_RSVD) &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !r_outValid));

   readback_rr_grant u_grant (
      .i_req  ({nl_valid, mac_valid}),
      .i_mask (w_mask),
      .i_ptr  (r_grant),
      .o_gnt  (w_gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (cfg_abort) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_armOk)
                  w_nextState = (cfg_count == '0) ? ST_DONE : ST_ARMED;
            end
            ST_ARMED: begin
               if (trig)
                  w_nextState = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (w_lastBeat || w_timeoutHit)
                  w_nextState = ST_DONE;
            end
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // Idle/armed flush stale FIFO samples; DONE backpressures both sources
   always_comb begin
      mac_ready = 1'b0;
      nl_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            mac_ready = 1'b1;
            nl_ready  = 1'b1;
         end
         ST_ARMED: begin
            mac_ready = 1'b1;
            nl_ready  = 1'b1;
            busy      = 1'b1;
         end
         ST_CAPTURE: begin
            mac_ready = !w_gnt && w_accept && !cfg_abort;
            nl_ready  = w_gnt && w_accept && !cfg_abort;
            busy      = 1'b1;
         end
         default: done = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode     <= MODE_MAC;
         r_count    <= '0;
         r_captured <= '0;
         r_grant    <= 1'b0;
         r_outData  <= '0;
         r_outSrc   <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         if (cfg_abort) begin
            r_outValid <= 1'b0;
         end else if (w_fire) begin
            r_outData  <= w_gnt ? nl_data : mac_data;
            r_outSrc   <= w_gnt;
            r_outValid <= 1'b1;
         end else if (out_ready) begin
            r_outValid <= 1'b0;
         end

         if (w_armOk && !cfg_abort) begin
            r_mode     <= cap_mode_t'(cfg_mode);
            r_count    <= cfg_count;
            r_captured <= '0;
            r_grant    <= 1'b0;
         end else if (w_fire) begin
            r_captured <= r_captured + 1'b1;
            if (r_mode == MODE_RR)
               r_grant <= ~w_gnt;
         end
      end
   end

`ifdef CAPTURE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_idleCnt;
   logic            r_timeout;

   assign w_timeoutHit = (r_state == ST_CAPTURE) && !w_fire && !cfg_abort &&
                         (r_idleCnt == TO_W'(TIMEOUT_CYC - 1));

   // Counter sits at zero outside CAPTURE, so it is fresh on entry and restarts per beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idleCnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_armOk && !cfg_abort)
            r_timeout <= 1'b0;
         else if (w_timeoutHit)
            r_timeout <= 1'b1;

         if ((r_state != ST_CAPTURE) || w_fire)
            r_idleCnt <= '0;
         else
            r_idleCnt <= r_idleCnt + 1'b1;
      end
   end

   assign timeout = r_timeout;
`else
   logic w_unusedTimeoutCyc;
   assign w_unusedTimeoutCyc = (TIMEOUT_CYC == 0);
   assign w_timeoutHit       = 1'b0;
   assign timeout            = 1'b0;
`endif

   assign out_data  = r_outData;
   assign out_src   = r_outSrc;
   assign out_valid = r_outValid;
   assign state     = r_state;
   assign captured  = r_captured;

endmodule

// File: tb/tb_readback_capture_arbiter.sv
// Directed table-driven bench for readback_capture_arbiter plus backpressure/abort/timeout sequences.
module tb_readback_capture_arbiter;

   logic         clk;
   logic         rst;
   logic         cfg_arm;
   logic         cfg_abort;
   logic [1:0]   cfg_mode;
   logic [15:0]  cfg_count;
   logic         trig;
   logic [127:0] mac_data;
   logic         mac_valid;
   logic         mac_ready;
   logic [127:0] nl_data;
   logic         nl_valid;
   logic         nl_ready;
   logic [127:0] out_data;
   logic         out_src;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         done;
   logic [1:0]   state;
   logic [15:0]  captured;
   logic         timeout;

   int total;
   int bad;

   readback_capture_arbiter #(
      .DATA_W      (128),
      .CNT_W       (16),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_arm   (cfg_arm),
      .cfg_abort (cfg_abort),
      .cfg_mode  (cfg_mode),
      .cfg_count (cfg_count),
      .trig      (trig),
      .mac_data  (mac_data),
      .mac_valid (mac_valid),
      .mac_ready (mac_ready),
      .nl_data   (nl_data),
      .nl_valid  (nl_valid),
      .nl_ready  (nl_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .state     (state),
      .captured  (captured),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        arm;
      logic        abort;
      logic [1:0]  mode;
      logic [15:0] count;
      logic        trig;
      logic        macV;
      logic        nlV;
      logic        outRdy;
      logic        expMacRdy;
      logic        expNlRdy;
      logic [1:0]  expState;
      logic        expOv;
      logic        expSrc;
      logic [15:0] expCap;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs [23];

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Beat payloads carry a tag so the bench knows exactly which beat was forwarded
   task automatic applyStimulus(input logic arm, input logic abort, input logic [1:0] mode,
                                input logic [15:0] count, input logic tr, input logic mv,
                                input logic nv, input logic rdy, input logic [31:0] tag);
      cfg_arm   = arm;
      cfg_abort = abort;
      cfg_mode  = mode;
      cfg_count = count;
      trig      = tr;
      mac_valid = mv;
      nl_valid  = nv;
      out_ready = rdy;
      mac_data  = {96'd0, 32'h1000_0000 | tag};
      nl_data   = {96'd0, 32'h2000_0000 | tag};
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int   seqSent;
   int   recv;
   logic rdy;
   logic hs;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      //                 arm   abort mode   count   trig  macV  nlV   rdy   mRdy  nRdy  st    ov    src   cap     data
      vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd1, 32'h1000_0002};
      vecs[3]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd2, 32'h1000_0003};
      vecs[4]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd3, 32'h1000_0004};
      vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 16'd4, 32'h1000_0005};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd4, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[9]  = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd1, 32'h1000_0009};
      vecs[10] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'd2, 32'h2000_000A};
      vecs[11] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd3, 32'h1000_000B};
      vecs[12] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'd4, 32'h2000_000C};
      vecs[13] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd5, 32'h1000_000D};
      vecs[14] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 16'd6, 32'h2000_000E};
      vecs[15] = '{1'b0, 1'b0, 2'd2, 16'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd6, 32'h0};
      vecs[16] = '{1'b1, 1'b0, 2'd2, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[17] = '{1'b0, 1'b0, 2'd2, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'd0, 32'h0};
      vecs[18] = '{1'b0, 1'b0, 2'd2, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'd1, 32'h2000_0012};
      vecs[19] = '{1'b0, 1'b0, 2'd2, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 16'd2, 32'h2000_0013};
      vecs[20] = '{1'b0, 1'b0, 2'd2, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 16'd3, 32'h2000_0014};
      vecs[21] = '{1'b1, 1'b0, 2'd0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 16'd3, 32'h2000_0014};
      vecs[22] = '{1'b0, 1'b0, 2'd0, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 16'd3, 32'h0};

      tick;
      tick;
      checkOutput("reset_state", state, 2'd0);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_out_src", out_src, 1'b0);
      checkOutput("reset_out_data", out_data, 128'd0);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_captured", captured, 16'd0);
      checkOutput("reset_timeout", timeout, 1'b0);
      rst = 1'b1;

      for (int i = 0; i < 23; i++) begin
         applyStimulus(vecs[i].arm, vecs[i].abort, vecs[i].mode, vecs[i].count, vecs[i].trig,
                       vecs[i].macV, vecs[i].nlV, vecs[i].outRdy, 32'(i));
         checkOutput($sformatf("v%0d_mac_ready", i), mac_ready, vecs[i].expMacRdy);
         checkOutput($sformatf("v%0d_nl_ready", i), nl_ready, vecs[i].expNlRdy);
         tick;
         checkOutput($sformatf("v%0d_state", i), state, vecs[i].expState);
         checkOutput($sformatf("v%0d_out_valid", i), out_valid, vecs[i].expOv);
         checkOutput($sformatf("v%0d_captured", i), captured, vecs[i].expCap);
         checkOutput($sformatf("v%0d_busy", i), busy, (vecs[i].expState == 2'd1) || (vecs[i].expState == 2'd2));
         checkOutput($sformatf("v%0d_done", i), done, vecs[i].expState == 2'd3);
         if (vecs[i].expOv) begin
            checkOutput($sformatf("v%0d_out_src", i), out_src, vecs[i].expSrc);
            checkOutput($sformatf("v%0d_out_data", i), out_data, {96'd0, vecs[i].expData});
         end
      end

      // Backpressure: reader stalls 3 cycles mid-capture; every beat must arrive once, in order
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd6, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("bp_arm_state", state, 2'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("bp_trig_state", state, 2'd2);
      seqSent = 0;
      recv    = 0;
      for (int i = 0; i < 40 && recv < 6; i++) begin
         rdy = !(i >= 3 && i <= 5);
         applyStimulus(1'b0, 1'b0, 2'd0, 16'd6, 1'b0, 1'b1, 1'b0, rdy, 32'(seqSent));
         if (out_valid && !rdy) begin
            checkOutput("bp_stall_mac_ready", mac_ready, 1'b0);
            checkOutput("bp_hold_data", out_data, {96'd0, 32'h1000_0000 | 32'(recv)});
         end
         if (out_valid && rdy) begin
            checkOutput("bp_beat_data", out_data, {96'd0, 32'h1000_0000 | 32'(recv)});
            recv++;
         end
         hs = mac_ready && mac_valid;
         tick;
         if (hs) seqSent++;
      end
      checkOutput("bp_recv_count", 32'(recv), 32'd6);
      checkOutput("bp_sent_count", 32'(seqSent), 32'd6);
      checkOutput("bp_state", state, 2'd3);
      checkOutput("bp_captured", captured, 16'd6);

      // Abort after two beats keeps the count for readback; re-arm clears it
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd10, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd10, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("ab_capture_state", state, 2'd2);
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd10, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd10, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("ab_pre_captured", captured, 16'd2);
      checkOutput("ab_pre_out_valid", out_valid, 1'b1);
      applyStimulus(1'b0, 1'b1, 2'd0, 16'd10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick;
      checkOutput("ab_state", state, 2'd0);
      checkOutput("ab_out_valid", out_valid, 1'b0);
      checkOutput("ab_captured", captured, 16'd2);
      checkOutput("ab_busy", busy, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("rearm_state", state, 2'd1);
      checkOutput("rearm_captured", captured, 16'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 16'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("ab_armed_state", state, 2'd0);
      applyStimulus(1'b1, 1'b0, 2'd3, 16'd5, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("rsvd_mode_state", state, 2'd0);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("zero_count_state", state, 2'd3);
      checkOutput("zero_count_done", done, 1'b1);
      checkOutput("zero_count_captured", captured, 16'd0);

      // Sources go silent during CAPTURE
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("to_arm_state", state, 2'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("to_capture_state", state, 2'd2);
      applyStimulus(1'b0, 1'b0, 2'd0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
`ifdef CAPTURE_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         tick;
         checkOutput($sformatf("to_wait%0d_state", i), state, 2'd2);
      end
      tick;
      checkOutput("to_expire_state", state, 2'd3);
      checkOutput("to_expire_flag", timeout, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("to_rearm_flag", timeout, 1'b0);
      checkOutput("to_rearm_state", state, 2'd1);
`else
      for (int i = 0; i < 12; i++) tick;
      checkOutput("noto_state", state, 2'd2);
      checkOutput("noto_flag", timeout, 1'b0);
`endif
      applyStimulus(1'b0, 1'b1, 2'd0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      tick;
      checkOutput("final_abort_state", state, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
